// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory arbiter slice:
//   - arbiter state encoding (ARB_IDLE, ARB_EXT_ACK)
//   - word-address width of a 32-bit byte address
//   - default starvation bound for the EXT port
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int unsigned WORD_ADDR_W      = 30;
    localparam int unsigned DEFAULT_MAX_WAIT = 8;

    localparam logic [0:0] ARB_IDLE    = 1'b0;
    localparam logic [0:0] ARB_EXT_ACK = 1'b1;

endpackage

// File: rtl/dmem_starve_cnt.sv
// -----------------------------------------------------------------------------
// dmem_starve_cnt
// Saturating EXT wait counter. Counts idle-state cycles in which EXT is
// requesting but not granted, and raises force_gnt once the count reaches
// MAX_WAIT so the arbiter can override CPU priority for one cycle.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   ext_req    in   EXT request
//   ext_gnt    in   EXT granted this cycle
//   idle       in   arbiter is in ARB_IDLE (EXT eligible)
//   force_gnt  out  forced-grant request to the arbiter
// -----------------------------------------------------------------------------
module dmem_starve_cnt
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic reset,
    input  logic ext_req,
    input  logic ext_gnt,
    input  logic idle,
    output logic force_gnt
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!ext_req || ext_gnt) begin
            wait_cnt <= '0;
        end else if (idle && (wait_cnt != MAX_CNT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign force_gnt = (wait_cnt == MAX_CNT) & ext_req & idle;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the MEM stage (CPU port, fixed
// priority, zero added latency) and an external requester (EXT port, granted
// when the CPU is idle, acked one cycle after the grant).
//
// Optional feature macro: DMEM_ARB_STARVE_EN
//   defined   -> starvation guard: after MAX_WAIT waiting cycles EXT is forced
//                through and the CPU is stalled for that one cycle.
//   undefined -> strict CPU priority, EXT may starve, cpu_stall stays 0.
//
// Ports:
//   clk, reset                      clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_rdata, cpu_stall   CPU (MEM stage) side
//   ext_req/we/addr/wdata, ext_rdata, ext_ack, ext_err   EXT side
//   mem_addr/wdata/read/write, mem_rdata            data memory pins
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned RAM_SIZE = 1024,
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    // CPU port
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    // EXT port
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic [31:0] ext_rdata,
    output logic        ext_ack,
    output logic        ext_err,
    // data memory
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] RAM_WORDS = 32'(RAM_SIZE);

    logic [0:0]             state;
    logic                   idle;
    logic                   force_gnt;
    logic                   ext_gnt;
    logic                   cpu_gnt;
    logic                   ext_oor;
    logic [WORD_ADDR_W-1:0] ext_word;

    assign idle     = (state == ARB_IDLE);
    assign ext_word = ext_addr[31:2];
    assign ext_oor  = ({2'b00, ext_word} >= RAM_WORDS);

`ifdef DMEM_ARB_STARVE_EN
    dmem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk       (clk),
        .reset     (reset),
        .ext_req   (ext_req),
        .ext_gnt   (ext_gnt),
        .idle      (idle),
        .force_gnt (force_gnt)
    );
`else
    assign force_gnt = 1'b0;
`endif

    // Grants are qualified with reset so the memory pins and the stall stay
    // quiet while reset is held, independent of the request inputs.
    assign ext_gnt   = reset & ext_req & idle & (~cpu_req | force_gnt);
    assign cpu_gnt   = reset & cpu_req & ~ext_gnt;
    assign cpu_stall = reset & cpu_req & ~cpu_gnt;
    assign cpu_rdata = mem_rdata;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = ~cpu_we;
            mem_write = cpu_we;
        end else if (ext_gnt) begin
            // Out-of-range EXT grants still consume the slot but never
            // touch the memory.
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_read  = ~ext_we & ~ext_oor;
            mem_write = ext_we & ~ext_oor;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            ext_ack   <= 1'b0;
            ext_err   <= 1'b0;
            ext_rdata <= '0;
        end else begin
            ext_ack <= ext_gnt;
            ext_err <= ext_gnt & ext_oor;
            if (ext_gnt) begin
                ext_rdata <= (ext_we | ext_oor) ? '0 : mem_rdata;
            end
            case (state)
                ARB_IDLE:    state <= ext_gnt ? ARB_EXT_ACK : ARB_IDLE;
                ARB_EXT_ACK: state <= ARB_IDLE;
                default:     state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter with a behavioural data memory behind
// the mem_* pins. EXT responses are predicted when a request is issued and
// compared when ext_ack appears. Cycle n of a contention run is the clock
// period that ends at rising edge n, with requests applied just after edge 0.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int unsigned MAX_WAIT = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata, ext_rdata;
    logic        ext_ack, ext_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [31:0] ram     [0:1023];
    logic [31:0] ref_mem [0:1023];
    exp_t        exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cycles = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .RAM_SIZE (1024),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_rdata (ext_rdata),
        .ext_ack   (ext_ack),
        .ext_err   (ext_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    // Behavioural single-port data memory (word indexed, address aliases).
    always_comb mem_rdata = ram[mem_addr[11:2]];
    always @(posedge clk) if (mem_write) ram[mem_addr[11:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (mem_write) wr_cycles++;

    // Scoreboard consumer: every ack must match the oldest predicted response.
    always @(negedge clk) begin
        if (reset && ext_ack) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(ext_ack), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ext_rdata", ext_rdata, e.rdata);
                check("ext_err", 32'(ext_err), 32'(e.err));
            end
        end
    end

    // Uncontended EXT transfer; starts and ends just after a rising edge.
    task automatic ext_xfer(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat);
        exp_t e;
        logic oor;
        oor     = (addr[31:2] >= 30'd1024);
        e.err   = oor;
        e.rdata = (we | oor) ? 32'h0 : ref_mem[addr[11:2]];
        if (we && !oor) ref_mem[addr[11:2]] = wdata;
        exp_q.push_back(e);
        ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
        @(negedge clk);
        check("ext_mem_read", 32'(mem_read), 32'(!we && !oor));
        check("ext_mem_write", 32'(mem_write), 32'(we && !oor));
        lat = 0;
        while (!ext_ack && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!ext_ack) check("ext_ack_timeout", 32'(ext_ack), 32'd1);
        @(posedge clk); #1;
        ext_req = 1'b0;
        @(negedge clk);
        check("ext_ack_pulse", 32'(ext_ack), 32'd0);
        @(posedge clk); #1;
    endtask

    // CPU loads continuously while EXT requests a read of word 256.
    task automatic contend(output int gnt_cyc, output int stall_cnt,
                           output int stall_cyc, output int ack_cyc);
`ifdef DMEM_ARB_STARVE_EN
        exp_t e;
        e.rdata = ref_mem[256];
        e.err   = 1'b0;
        exp_q.push_back(e);
`endif
        gnt_cyc = -1; stall_cnt = 0; stall_cyc = -1; ack_cyc = -1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h400;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (mem_read && mem_addr == 32'h400 && gnt_cyc < 0) gnt_cyc = n;
            if (cpu_stall) begin
                stall_cnt++;
                if (stall_cyc < 0) stall_cyc = n;
            end
            if (ext_ack && ack_cyc < 0) ack_cyc = n;
            @(posedge clk); #1;
            if (ack_cyc > 0) ext_req = 1'b0;
        end
        ext_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, g, s, sc, a;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h1;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0;  ext_wdata = 32'h0;

        // Reset state, with both requests asserted to prove gating.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ext_ack", 32'(ext_ack), 32'd0);
        check("rst_ext_err", 32'(ext_err), 32'd0);
        check("rst_ext_rdata", ext_rdata, 32'h0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; ext_req = 1'b0;
        reset = 1'b1;
        wr_cycles = 0;

        // CPU store then load.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        @(negedge clk);
        check("cpu_st_mem_write", 32'(mem_write), 32'd1);
        check("cpu_st_mem_addr", mem_addr, 32'h10);
        check("cpu_st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("cpu_st_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        cpu_we = 1'b0;
        @(negedge clk);
        check("cpu_ld_mem_read", 32'(mem_read), 32'd1);
        check("cpu_ld_rdata", cpu_rdata, ref_mem[4]);
        check("cpu_ld_stall", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_wr_cycles", 32'(wr_cycles), 32'd1);
        @(posedge clk); #1;

        // EXT write/read, top-of-range word, out-of-range read and write.
        ext_xfer(1'b1, 32'h400, 32'h12345678, lat);
        check("ext_wr_lat", 32'(lat), 32'd1);
        ext_xfer(1'b0, 32'h400, 32'h0, lat);
        check("ext_rd_lat", 32'(lat), 32'd1);
        ext_xfer(1'b1, 32'hFFC, 32'hA5A55A5A, lat);
        ext_xfer(1'b0, 32'hFFC, 32'h0, lat);
        ext_xfer(1'b0, 32'h1000, 32'h0, lat);
        check("ext_oor_rd_lat", 32'(lat), 32'd1);
        ext_xfer(1'b1, 32'h1000, 32'hBADBAD00, lat);
        // 0x1000 aliases to word 0 in the bench memory: it must be untouched.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
        @(negedge clk);
        check("oor_wr_no_effect", cpu_rdata, ref_mem[0]);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // Contention under continuous CPU load.
        contend(g, s, sc, a);
`ifdef DMEM_ARB_STARVE_EN
        check("cont_gnt_cycle", 32'(g), 32'(MAX_WAIT + 1));
        check("cont_stall_count", 32'(s), 32'd1);
        check("cont_stall_cycle", 32'(sc), 32'(MAX_WAIT + 1));
        check("cont_ack_cycle", 32'(a), 32'(MAX_WAIT + 2));
`else
        check("cont_gnt_cycle", 32'(g), 32'hFFFF_FFFF);
        check("cont_stall_count", 32'(s), 32'd0);
        check("cont_ack_cycle", 32'(a), 32'hFFFF_FFFF);
`endif
        @(posedge clk); #1;

        // Reset asserted in the ack cycle.
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h400;
        @(negedge clk);
        @(posedge clk); #1;
        check("ack_before_rst", 32'(ext_ack), 32'd1);
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
        #1;
        check("rst_ack_cleared", 32'(ext_ack), 32'd0);
        check("rst_mid_mem_read", 32'(mem_read), 32'd0);
        check("rst_mid_mem_write", 32'(mem_write), 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'h0);
        check("rst_mid_mem_wdata", mem_wdata, 32'h0);
        check("rst_mid_stall", 32'(cpu_stall), 32'd0);
        ext_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        ext_xfer(1'b0, 32'h400, 32'h0, lat);
        check("post_rst_idle_lat", 32'(lat), 32'd1);

        // Partial wait, then reset: the wait count must restart from zero.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h400;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        contend(g, s, sc, a);
`ifdef DMEM_ARB_STARVE_EN
        check("rst_wait_gnt_cycle", 32'(g), 32'(MAX_WAIT + 1));
        check("rst_wait_ack_cycle", 32'(a), 32'(MAX_WAIT + 2));
`else
        check("rst_wait_gnt_cycle", 32'(g), 32'hFFFF_FFFF);
        check("rst_wait_stall_count", 32'(s), 32'd0);
`endif
        @(posedge clk); #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
